// File: rtl/iot_event_encoder_pkg.sv
// Shared constants for the device-monitor path (event encoder and the downstream active-device counter).
package iot_mon_pkg;

    localparam int   N_DEV_DEFAULT = 8;
    localparam logic EV_ON         = 1'b1;
    localparam logic EV_OFF        = 1'b0;
    localparam int   CNT_OUT_W     = 8;

    // Index width that stays at least one bit wide for tiny device counts.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iot_event_encoder_if.sv
// Status-in / event-out bundle of the event encoder; master is the encoder, slave its environment.
interface iot_event_encoder_if #(
    parameter int N_DEV = iot_mon_pkg::N_DEV_DEFAULT
) ();

    localparam int ID_W  = iot_mon_pkg::id_width(N_DEV);
    localparam int CNT_W = $clog2(N_DEV + 1);

    logic [N_DEV-1:0] dev_status;
    logic             hold;
    logic             change;
    logic             on_off;
    logic [ID_W-1:0]  dev_id;
    logic [CNT_W-1:0] pend_cnt;

    modport master (
        input  dev_status,
        input  hold,
        output change,
        output on_off,
        output dev_id,
        output pend_cnt
    );

    modport slave (
        output dev_status,
        output hold,
        input  change,
        input  on_off,
        input  dev_id,
        input  pend_cnt
    );

endinterface

// File: rtl/iot_event_encoder_arb.sv
// Combinational round-robin arbiter: first set request at or after last+1, wrapping; the pointer lives in the parent.
module rr_arbiter #(
    parameter  int N    = 8,
    localparam int ID_W = iot_mon_pkg::id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic            gnt_vld,
    output logic [ID_W-1:0] gnt_idx
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 1; k <= N; k++) begin
            idx   = (int'(last) + k) % N;
            idx_w = ID_W'(idx);
            if (!gnt_vld && req[idx_w]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_w;
            end
        end
    end

endmodule

// File: rtl/iot_event_encoder.sv
// Serialises per-device online/offline transitions into one change/on_off event per clock.
// Optional STATUS_SYNC_EN inserts a two-flop synchronizer on dev_status ahead of the sample register.
module iot_event_encoder
    import iot_mon_pkg::*;
#(
    parameter int N_DEV = N_DEV_DEFAULT
) (
    input logic                 clk,
    input logic                 rst,
    iot_event_encoder_if.master bus
);

    localparam int ID_W  = id_width(N_DEV);
    localparam int CNT_W = $clog2(N_DEV + 1);

    logic [N_DEV-1:0] status_in;
    logic [N_DEV-1:0] s_q;
    logic [N_DEV-1:0] rep;
    logic [N_DEV-1:0] pend;
    logic [ID_W-1:0]  last_g;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_idx;
    logic             change_q;
    logic             on_off_q;
    logic [ID_W-1:0]  dev_id_q;

`ifdef STATUS_SYNC_EN
    logic [N_DEV-1:0] sync_1;
    logic [N_DEV-1:0] sync_2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= bus.dev_status;
            sync_2 <= sync_1;
        end
    end

    assign status_in = sync_2;
`else
    assign status_in = bus.dev_status;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= status_in;
        end
    end

    // A device that toggles back to its reported level before being granted drops out of pend by itself.
    assign pend = s_q ^ rep;

    rr_arbiter #(
        .N (N_DEV)
    ) u_arb (
        .req     (pend),
        .last    (last_g),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // rep[g] takes the pre-edge sample, so a device changing again on its grant edge re-reports next time round.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep      <= '0;
            last_g   <= ID_W'(N_DEV - 1);
            change_q <= 1'b0;
            on_off_q <= 1'b0;
            dev_id_q <= '0;
        end else if (!bus.hold && gnt_vld) begin
            change_q     <= 1'b1;
            on_off_q     <= s_q[gnt_idx] ? EV_ON : EV_OFF;
            dev_id_q     <= gnt_idx;
            rep[gnt_idx] <= s_q[gnt_idx];
            last_g       <= gnt_idx;
        end else begin
            change_q <= 1'b0;
        end
    end

    assign bus.change   = change_q;
    assign bus.on_off   = on_off_q;
    assign bus.dev_id   = dev_id_q;
    assign bus.pend_cnt = CNT_W'($countones(pend));

endmodule

// File: tb/tb_iot_event_encoder.sv
// Self-checking bench for iot_event_encoder: directed vector table, corner sequences and random traffic vs a model.
module tb_iot_event_encoder;
    import iot_mon_pkg::*;

    localparam int N = 8;

    typedef struct {
        bit       r;
        bit       h;
        bit [7:0] ds;
        bit       ch;
        bit       oo;
        int       id;
        int       pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    iot_event_encoder_if #(.N_DEV(N)) bus_if ();

    iot_event_encoder #(
        .N_DEV (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Reference model state: what the outputs and bookkeeping must be after each edge.
    bit [N-1:0] m_sq;
    bit [N-1:0] m_rep;
    int         m_last;
    bit         m_change;
    bit         m_on;
    int         m_id;
    int         counter;
    int         ages[N];
    int         max_age;
    int         n_checks = 0;
    int         n_fail   = 0;
    vec_t       vecs[$];

    function automatic int popc(input bit [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += v[i];
        return c;
    endfunction

    task automatic modelEdge(input bit r, input bit h, input bit [N-1:0] ds);
        int g;
        if (r) begin
            m_sq = '0; m_rep = '0; m_last = N - 1;
            m_change = 1'b0; m_on = 1'b0; m_id = 0;
        end else begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && m_sq[(m_last + k) % N] != m_rep[(m_last + k) % N]) g = (m_last + k) % N;
            end
            if (!h && g >= 0) begin
                m_change = 1'b1;
                m_on     = m_sq[g];
                m_id     = g;
                m_rep[g] = m_sq[g];
                m_last   = g;
            end else begin
                m_change = 1'b0;
            end
            m_sq = ds;
        end
    endtask

    task automatic applyStimulus(input bit r, input bit h, input bit [N-1:0] ds);
        rst               = r;
        bus_if.hold       = h;
        bus_if.dev_status = ds;
        @(posedge clk);
        modelEdge(r, h, ds);
        #1;
        if (r) begin
            counter = 0;
        end else if (bus_if.change === 1'b1) begin
            counter = (counter + (bus_if.on_off ? 1 : -1) + 256) % 256;
        end
        for (int i = 0; i < N; i++) begin
            if (r || (bus_if.change === 1'b1 && int'(bus_if.dev_id) == i) || m_sq[i] == m_rep[i]) begin
                ages[i] = 0;
            end else begin
                ages[i]++;
                if (ages[i] > max_age) max_age = ages[i];
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".change"},   int'(bus_if.change),   int'(m_change));
        check({tag, ".on_off"},   int'(bus_if.on_off),   int'(m_on));
        check({tag, ".dev_id"},   int'(bus_if.dev_id),   m_id);
        check({tag, ".pend_cnt"}, int'(bus_if.pend_cnt), popc(m_sq ^ m_rep));
    endtask

    initial begin
        bus_if.hold       = 1'b0;
        bus_if.dev_status = '0;
        counter = 0;
        max_age = 0;
        foreach (ages[i]) ages[i] = 0;

        // Idle after reset: nothing may come out.
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            checkOutput("idle");
        end

        // Hand-derived vectors: single device on/off, full burst from reset, glitch under hold.
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{1'b0, 1'b0, 8'h08, 1'b1, 1'b1, 3, 0});
        vecs.push_back('{1'b0, 1'b0, 8'h08, 1'b0, 1'b1, 3, 0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3, 1});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3, 0});
        vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3, 0});
        vecs.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 0, 8});
        for (int k = 0; k < 8; k++) vecs.push_back('{1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, k, 7 - k});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 7, 0});
        vecs.push_back('{1'b0, 1'b1, 8'hDF, 1'b0, 1'b1, 7, 1});
        vecs.push_back('{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 7, 0});
        vecs.push_back('{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 7, 0});
        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].r, vecs[v].h, vecs[v].ds);
            check($sformatf("vec%0d.change", v),   int'(bus_if.change),   int'(vecs[v].ch));
            check($sformatf("vec%0d.on_off", v),   int'(bus_if.on_off),   int'(vecs[v].oo));
            check($sformatf("vec%0d.dev_id", v),   int'(bus_if.dev_id),   vecs[v].id);
            check($sformatf("vec%0d.pend_cnt", v), int'(bus_if.pend_cnt), vecs[v].pc);
        end
        check("burst.counter", counter, 8);

        // Fairness: pointer at 2 with devices 1 and 6 pending must grant 6 before 1.
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h04);
        applyStimulus(1'b0, 1'b0, 8'h04);
        check("fair.grant2", int'(bus_if.dev_id), 2);
        applyStimulus(1'b0, 1'b0, 8'h46);
        checkOutput("fair.capture");
        applyStimulus(1'b0, 1'b0, 8'h46);
        check("fair.first_change", int'(bus_if.change), 1);
        check("fair.first_id", int'(bus_if.dev_id), 6);
        applyStimulus(1'b0, 1'b0, 8'h46);
        check("fair.second_change", int'(bus_if.change), 1);
        check("fair.second_id", int'(bus_if.dev_id), 1);

        // Device 0 toggling every other cycle must not starve devices 2, 4 and 7.
        max_age = 0;
        for (int c = 0; c < 24; c++) begin
            bit [N-1:0] ds;
            ds    = (c < 12) ? 8'hD2 : 8'h46;
            ds[0] = ((c / 2) % 2) == 1;
            applyStimulus(1'b0, 1'b0, ds);
            checkOutput("starve");
        end
        check("starve.max_wait_ok", int'(max_age <= N), 1);

        // Reset in the middle of a burst throws away pending work; active devices re-report.
        applyStimulus(1'b1, 1'b0, 8'h00);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b0, 8'hFF);
        check("midrst.counter_before", counter, 5);
        applyStimulus(1'b1, 1'b0, 8'hFF);
        check("midrst.change", int'(bus_if.change), 0);
        check("midrst.pend_cnt", int'(bus_if.pend_cnt), 0);
        applyStimulus(1'b0, 1'b0, 8'hFF);
        checkOutput("midrst.capture");
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, 8'hFF);
            check($sformatf("midrst.ev%0d.change", k), int'(bus_if.change), 1);
            check($sformatf("midrst.ev%0d.on_off", k), int'(bus_if.on_off), 1);
            check($sformatf("midrst.ev%0d.dev_id", k), int'(bus_if.dev_id), k);
        end
        check("midrst.counter_after", counter, 8);

        // Random traffic: sparse bit flips, occasional hold and reset, everything against the model.
        begin
            bit [N-1:0] ds;
            ds = 8'hFF;
            for (int c = 0; c < 400; c++) begin
                bit h;
                bit r;
                for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) ds[i] = ~ds[i];
                h = ($urandom_range(0, 4) == 0);
                r = ($urandom_range(0, 59) == 0);
                applyStimulus(r, h, ds);
                checkOutput("rand");
            end
        end
        for (int c = 0; c < N + 2; c++) begin
            applyStimulus(1'b0, 1'b0, bus_if.dev_status);
            checkOutput("drain");
        end
        check("rand.counter_vs_rep", counter, popc(m_rep) % 256);
        check("rand.drained", int'(bus_if.pend_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
